icache_meta_array: RTL

//  - Parametrised N-way metadata array (valid/dirty/state bits) for the instruction cache; one entry per way per set.
//  - Single port with a registered read of all ways at once and a per-way write.
//  - A built-in invalidate sweep clears the whole array after reset or on request.
//  - Sits between the I-cache controller and its tag/data arrays; the controller reads all ways for hit/victim selection.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_meta_way.sv | 25 ++
 rtl/icache_meta_array.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared I-cache definitions: index width, metadata width, sweep FSM
// states and a constant-foldable clog2 helper.
// I_INDEX_WIDTH may be supplied on the command line; it defaults to 4.
`ifndef I_INDEX_WIDTH
`define I_INDEX_WIDTH 4
`endif

package icache_pkg;

  localparam int unsigned I_INDEX_WIDTH = `I_INDEX_WIDTH;
  localparam int unsigned META_DW       = 2;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } meta_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/icache_meta_way.sv
// One way of the metadata array: NUM entries of EW bits, a single write
// port and an asynchronous read of the addressed entry. Contents are not
// reset; the owning array clears them with its invalidate sweep.
module icache_meta_way #(
  parameter int unsigned EW  = 2,
  parameter int unsigned AW  = 4,
  parameter int unsigned NUM = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [EW-1:0] wdata,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [NUM];

  // Storage write on the addressed entry.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/icache_meta_array.sv
// N-way I-cache metadata array with registered all-way read, per-way
// write and a full invalidate sweep after reset or on inv_req.
// Optional feature macro: ICACHE_META_PARITY_EN adds a parity bit per
// entry and the per-way par_err output.
module icache_meta_array
  import icache_pkg::*;
#(
  parameter int unsigned DW   = META_DW,
  parameter int unsigned AW   = I_INDEX_WIDTH,
  parameter int unsigned NUM  = (32'd1 << AW),
  parameter int unsigned WAYS = 4,
  parameter int unsigned WW   = (clog2(WAYS) < 1) ? 1 : clog2(WAYS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               we,
  input  logic [AW-1:0]      index,
  input  logic [WW-1:0]      way,
  input  logic [DW-1:0]      din,
  input  logic               inv_req,
  output logic [WAYS*DW-1:0] dout,
  output logic               dout_valid,
  output logic               busy
`ifdef ICACHE_META_PARITY_EN
  ,
  output logic [WAYS-1:0]    par_err
`endif
);

`ifdef ICACHE_META_PARITY_EN
  localparam int unsigned EW = DW + 1;
`else
  localparam int unsigned EW = DW;
`endif

  meta_state_e        state, state_nx;
  logic [AW-1:0]      cnt, cnt_nx;
  logic               access;
  logic               rd_req;
  logic [AW-1:0]      addr;
  logic [EW-1:0]      wdata;
  logic [WAYS-1:0]    way_we;
  logic [EW-1:0]      rdata [WAYS];
  logic [WAYS*DW-1:0] rd_bus;

  // inv_req takes priority over any access presented in the same cycle.
  assign access = (state == IDLE) && en && !inv_req;
  assign rd_req = access && !we;
  assign busy   = (state == SWEEP);
  assign addr   = (state == SWEEP) ? cnt : index;

  // Sweep state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SWEEP;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Sweep sequencing: one set per edge, restart on inv_req.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      SWEEP: begin
        if (inv_req) begin
          cnt_nx = '0;
        end else if (cnt == AW'(NUM - 1)) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + AW'(1);
        end
      end
      IDLE: begin
        if (inv_req) begin
          state_nx = SWEEP;
          cnt_nx   = '0;
        end
      end
    endcase
  end

  // Write data and per-way write enables; a way code >= WAYS matches nothing.
  always_comb begin
    wdata  = '0;
    way_we = '0;
    if (state == IDLE) begin
`ifdef ICACHE_META_PARITY_EN
      wdata = {^din, din};
`else
      wdata = din;
`endif
    end
    for (int unsigned w = 0; w < WAYS; w++) begin
      way_we[w] = (state == SWEEP) || (access && we && (way == WW'(w)));
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_meta_way #(
      .EW (EW),
      .AW (AW),
      .NUM(NUM)
    ) u_way (
      .clk  (clk),
      .we   (way_we[w]),
      .addr (addr),
      .wdata(wdata),
      .rdata(rdata[w])
    );
  end

  // Pack the data field of every way into the read bus.
  always_comb begin
    rd_bus = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      rd_bus[w*DW +: DW] = rdata[w][DW-1:0];
    end
  end

`ifdef ICACHE_META_PARITY_EN
  logic [WAYS-1:0] perr;

  // Per-way parity recheck of the addressed entries.
  always_comb begin
    perr = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      perr[w] = (^rdata[w][DW-1:0]) != rdata[w][DW];
    end
  end

  // Parity error flags, valid only alongside read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= '0;
    else        par_err <= rd_req ? perr : '0;
  end
`endif

  // Output register: dout updates only on reads and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_req;
      if (rd_req) dout <= rd_bus;
    end
  end

endmodule
